// File: rtl/wave_capture_pkg.sv
// wave_capture_pkg: shared types and constants for the waveform capture block.
// Optional feature macro: WAVE_CAPTURE_TIMESTAMP_EN (trigger timestamp counter).
package wave_capture_pkg;

   localparam int SAMPLE_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // register word offsets
   localparam logic [31:0] REG_CTRL   = 32'd0;
   localparam logic [31:0] REG_STATUS = 32'd1;
   localparam logic [31:0] REG_THRESH = 32'd2;
   localparam logic [31:0] REG_LENGTH = 32'd3;
   localparam logic [31:0] REG_DATA   = 32'd4;
   localparam logic [31:0] REG_TSTAMP = 32'd5;

   // CTRL bit positions
   localparam int CTRL_ARM    = 0;
   localparam int CTRL_ABORT  = 1;
   localparam int CTRL_FORCE  = 2;
   localparam int CTRL_IRQ_EN = 3;

   // capture length is kept within 1..depth
   function automatic logic [31:0] clamp_len(input logic [31:0] v, input logic [31:0] depth);
      if (v == 32'd0) return 32'd1;
      if (v > depth)  return depth;
      return v;
   endfunction

endpackage

// File: rtl/wave_capture_if.sv
// wave_capture_if: Avalon-MM register slave bus plus interrupt line.
interface wave_capture_if #(
   parameter int AW = 3
) ();
   logic [AW-1:0] address;
   logic          read;
   logic          write;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic          irq;

   modport master (output address, read, write, writedata, input readdata, irq);
   modport slave  (input address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/wave_capture_buf.sv
// wave_capture_buf: DEPTH x 16 simple dual-port sample RAM, registered read port.
module wave_capture_buf
   import wave_capture_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [SAMPLE_W-1:0]      i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [SAMPLE_W-1:0]      o_rdata
);

   logic [SAMPLE_W-1:0] r_mem [DEPTH];

   // sample write port
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // registered read port; holds its value between reads
   always_ff @(posedge clk) begin
      if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl: threshold-triggered ADC waveform capture with Avalon-MM control.
// Optional feature macro: WAVE_CAPTURE_TIMESTAMP_EN latches a free-running cycle
// count at the trigger; without it TSTAMP reads 0.
module wave_capture_ctrl
   import wave_capture_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 3
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic signed [SAMPLE_W-1:0] adc_data,
   input  logic                       adc_valid,
   wave_capture_if.slave              bus
);

   localparam int ABW = $clog2(DEPTH);
   localparam int CW  = ABW + 1;

   state_t                     r_state;
   logic                       r_irq_en;
   logic signed [SAMPLE_W-1:0] r_thresh;
   logic signed [SAMPLE_W-1:0] r_prev;
   logic [CW-1:0]              r_length;
   logic [CW-1:0]              r_cap_len;
   logic [CW-1:0]              r_count;
   logic [CW-1:0]              r_rd_ptr;
   logic [31:0]                r_readdata;
   logic                       r_data_sel;
   logic                       r_data_zero;

   logic [AW-1:0]       w_addr_l;
   logic [31:0]         w_addr;
   logic                w_wr, w_rd, w_ctrl_wr;
   logic                w_arm, w_abort, w_force, w_cross, w_pop, w_we;
   logic [CW-1:0]       w_count_inc;
   logic [11:0]         w_cnt12;
   logic [SAMPLE_W-1:0] w_ram_q;
   logic [31:0]         w_tstamp;

   assign w_addr_l    = bus.address;
   assign w_addr      = 32'(w_addr_l);
   assign w_wr        = bus.write;
   assign w_rd        = bus.read & ~bus.write;
   assign w_ctrl_wr   = w_wr && (w_addr == REG_CTRL);
   assign w_arm       = w_ctrl_wr & bus.writedata[CTRL_ARM];
   assign w_abort     = w_ctrl_wr & bus.writedata[CTRL_ABORT];
   assign w_force     = w_ctrl_wr & bus.writedata[CTRL_FORCE];
   assign w_cross     = adc_valid && (r_prev < r_thresh) && (adc_data >= r_thresh);
   assign w_pop       = w_rd && (w_addr == REG_DATA) && (r_rd_ptr != r_count);
   assign w_count_inc = r_count + 1'b1;
   assign w_cnt12     = 12'(r_count);

   // a sample is stored on the crossing itself or on any valid sample while capturing
   assign w_we = !w_abort && adc_valid &&
                 (((r_state == ST_ARMED) && w_cross) || (r_state == ST_CAPTURE));

   wave_capture_buf #(.DEPTH(DEPTH)) u_buf (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_count[ABW-1:0]),
      .i_wdata (adc_data),
      .i_re    (w_pop),
      .i_raddr (r_rd_ptr[ABW-1:0]),
      .o_rdata (w_ram_q)
   );

   // previous sample for edge detection; the reset value blocks the first sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       r_prev <= 16'sh7FFF;
      else if (adc_valid) r_prev <= adc_data;
   end

   // capture FSM with sample count and readout pointer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_rd_ptr  <= '0;
         r_cap_len <= CW'(DEPTH);
      end else begin
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_abort) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE, ST_DONE: begin
                  if (w_arm) begin
                     r_state  <= ST_ARMED;
                     r_count  <= '0;
                     r_rd_ptr <= '0;
                  end
               end
               ST_ARMED: begin
                  if (w_cross) begin
                     r_cap_len <= r_length;
                     r_count   <= CW'(1);
                     r_state   <= (r_length == CW'(1)) ? ST_DONE : ST_CAPTURE;
                  end else if (w_force) begin
                     r_cap_len <= r_length;
                     r_state   <= ST_CAPTURE;
                  end
               end
               ST_CAPTURE: begin
                  if (adc_valid) begin
                     r_count <= w_count_inc;
                     if (w_count_inc == r_cap_len) r_state <= ST_DONE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   // configuration registers and read-data capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_en    <= 1'b0;
         r_thresh    <= '0;
         r_length    <= CW'(DEPTH);
         r_readdata  <= '0;
         r_data_sel  <= 1'b0;
         r_data_zero <= 1'b0;
      end else begin
         if (w_wr) begin
            case (w_addr)
               REG_CTRL:   r_irq_en <= bus.writedata[CTRL_IRQ_EN];
               REG_THRESH: r_thresh <= signed'(bus.writedata[SAMPLE_W-1:0]);
               REG_LENGTH: r_length <= CW'(clamp_len(bus.writedata, 32'(DEPTH)));
               default: ;
            endcase
         end
         if (w_rd) begin
            r_data_sel  <= (w_addr == REG_DATA);
            r_data_zero <= (r_rd_ptr == r_count);
            case (w_addr)
               REG_CTRL:   r_readdata <= 32'(r_irq_en) << CTRL_IRQ_EN;
               REG_STATUS: r_readdata <= {4'b0, w_cnt12, 14'b0, r_state};
               REG_THRESH: r_readdata <= {{16{r_thresh[SAMPLE_W-1]}}, r_thresh};
               REG_LENGTH: r_readdata <= 32'(r_length);
               REG_TSTAMP: r_readdata <= w_tstamp;
               default:    r_readdata <= '0;
            endcase
         end
      end
   end

`ifdef WAVE_CAPTURE_TIMESTAMP_EN
   logic        w_trig_evt;
   logic [31:0] r_ts_cnt;
   logic [31:0] r_tstamp;

   assign w_trig_evt = (r_state == ST_ARMED) && !w_abort && (w_cross || w_force);

   // free-running cycle count, latched on the trigger cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ts_cnt <= '0;
         r_tstamp <= '0;
      end else begin
         r_ts_cnt <= r_ts_cnt + 32'd1;
         if (w_trig_evt) r_tstamp <= r_ts_cnt;
      end
   end

   assign w_tstamp = r_tstamp;
`else
   assign w_tstamp = '0;
`endif

   // DATA reads come straight from the RAM output register to keep latency at one cycle
   assign bus.readdata = r_data_sel ?
                         (r_data_zero ? 32'd0 : {{16{w_ram_q[SAMPLE_W-1]}}, w_ram_q}) :
                         r_readdata;
   assign bus.irq      = (r_state == ST_DONE) && r_irq_en;

endmodule

// File: doc/wave_capture_ctrl.md
WAVE_CAPTURE_CTRL -- requirements
Module: wave_capture_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024, sample buffer depth in 16-bit words (power of two, 16..4096).
REQ-002 Parameter AW, default 3, Avalon-MM word address width.
REQ-003 clk  in  1  system clock; all logic synchronous to clk.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 adc_data  in  16  signed ADC sample, already in clk domain.
REQ-006 adc_valid  in  1  one-cycle strobe qualifying adc_data.
REQ-007 address  in  AW  Avalon-MM register word address.
REQ-008 read, write  in  1 each  Avalon-MM strobes; write has priority if both high.
REQ-009 writedata  in  32  Avalon-MM write data.
REQ-010 readdata  out  32  registered read data.
REQ-011 irq  out  1  level interrupt, high while DONE and IRQ_EN=1.

Function
REQ-012 Register map (word offsets):
- 0 CTRL: W bit0 ARM, bit1 ABORT, bit2 FORCE (self-clearing); RW bit3 IRQ_EN.
- 1 STATUS: R [1:0] state, [27:16] stored count.
- 2 THRESH: RW signed 16-bit trigger level.
- 3 LENGTH: RW capture length.
- 4 DATA: R pops next sample, sign-extended to 32 bits.
- 5 TSTAMP: R trigger timestamp.
- 6-7: read 0.
REQ-013 readdata valid exactly one cycle after read; fixed read latency 1, no waitrequest.
REQ-014 FSM states IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-015 IDLE/DONE --ARM--> ARMED; clears stored count and read pointer.
REQ-016 ARMED --trigger--> CAPTURE; trigger = adc_valid AND prev_sample < THRESH AND adc_data >= THRESH (signed), or FORCE.
REQ-017 prev_sample updates on every adc_valid in every state; after reset, first valid sample cannot trigger.
REQ-018 Triggering sample is stored as sample 0; FORCE stores next valid sample as sample 0.
REQ-019 CAPTURE: each adc_valid writes one sample, count increments; count == LENGTH --> DONE on the same cycle as the last write.
REQ-020 LENGTH writes clamp: 0 -> 1, >DEPTH -> DEPTH; reads return clamped value.
REQ-021 ABORT in any state --> IDLE, count kept; ABORT wins over simultaneous ARM/FORCE.
REQ-022 ARM in ARMED or CAPTURE ignored; FORCE outside ARMED ignored.
REQ-023 DATA read: returns buffer[rd_ptr], rd_ptr increments; rd_ptr == count returns 0, no increment; legal in any state.
REQ-024 THRESH/LENGTH writes during CAPTURE take effect for next capture only.

Reset
REQ-025 Reset: state IDLE, readdata 0, irq 0, IRQ_EN 0, THRESH 0, LENGTH DEPTH, count/rd_ptr 0, prev_sample 0x7FFF.
REQ-026 Reset mid-capture discards capture; buffer contents undefined, unreadable until next capture.

Configuration
REQ-027 Macro WAVE_CAPTURE_TIMESTAMP_EN defined: 32-bit free-running cycle counter (wraps), latched into TSTAMP at trigger cycle, reset 0.
REQ-028 Macro undefined: no counter; TSTAMP reads 0.

Structure
REQ-029 Package wave_capture_pkg: state enum, register offsets, CTRL bit positions, sample width 16.
REQ-030 Sub-module wave_capture_buf: DEPTH x 16 simple dual-port RAM, one write port, one registered read port.

Verification
REQ-031 LENGTH=4, THRESH=100, ARM, samples -5,50,150,200,10,300,7 -> DONE after 300; DATA reads 150,200,10,300, then 0.
REQ-032 ARM, samples constant 500 with THRESH=100 -> stays ARMED (no rising crossing); FORCE -> captures next sample.
REQ-033 ABORT and ARM in same write during CAPTURE with count=2 -> IDLE, STATUS count=2.
REQ-034 LENGTH write 0 -> reads 1; write 5000 (DEPTH=1024) -> reads 1024; full-depth capture, 1025th DATA read returns 0.
REQ-035 IRQ_EN=1, capture completes -> irq high; ARM -> irq low next cycle; reset_n low mid-capture -> STATUS=0, irq 0.
REQ-036 With WAVE_CAPTURE_TIMESTAMP_EN, trigger at cycle N after reset -> TSTAMP=N; without macro -> TSTAMP=0.
